// File: rtl/keypad_id_entry.sv
// 4x4 matrix keypad scanner with frame-based debounce and a 7-digit BCD ID entry buffer.
// Accepted digits shift into oEntry; '#' commits a full entry to oID and '*' removes the last digit.
module keypad_id_entry #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [3:0]  iROW,
    output logic [3:0]  oCOL,
    input  logic        iClear,
    output logic        oKeyValid,
    output logic [3:0]  oKeyCode,
    output logic [27:0] oEntry,
    output logic [2:0]  oDigitCount,
    output logic [27:0] oID,
    output logic        oIDReady,
    output logic        oEntryErr
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE);

    typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_RELEASE_CHK} state_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]       r_row_s1, r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [1:0]       r_acc_n;
    logic [3:0]       r_acc_code;
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [3:0]       r_code, w_code_nx;
    logic             w_accept;
    logic [3:0]       w_acc_code;
    logic             w_slot_end, w_frame_end;
    logic [3:0]       w_closed;
    logic [2:0]       w_ones, w_sum;
    logic [1:0]       w_slot_n, w_tot_n, w_slot_row;
    logic [3:0]       w_frame_code;
    logic [27:0]      r_entry, r_id;
    logic [2:0]       r_count;
    logic [3:0]       r_key_code;
    logic             r_kv, r_rdy, r_err;

    assign oCOL        = ~(4'b0001 << r_col);
    assign w_slot_end  = (r_div == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_col == 2'd3);
    assign w_closed    = ~r_row_s2;

    // Per-slot switch count (saturated at 2) folded into a running frame classification.
    always_comb begin
        w_ones     = 3'd0;
        w_slot_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_closed[i]) begin
                w_ones     = w_ones + 3'd1;
                w_slot_row = 2'(i);
            end
        end
        w_slot_n     = (w_ones >= 3'd2) ? 2'd2 : w_ones[1:0];
        w_sum        = {1'b0, r_acc_n} + {1'b0, w_slot_n};
        w_tot_n      = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        w_frame_code = (r_acc_n == 2'd0) ? key_map(w_slot_row, r_col) : r_acc_code;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_row_s1   <= 4'hF;
            r_row_s2   <= 4'hF;
            r_div      <= '0;
            r_col      <= 2'd0;
            r_acc_n    <= 2'd0;
            r_acc_code <= 4'h0;
        end else begin
            r_row_s1 <= iROW;
            r_row_s2 <= r_row_s1;
            if (w_slot_end) begin
                r_div <= '0;
                r_col <= r_col + 2'd1;
                if (w_frame_end) begin
                    r_acc_n    <= 2'd0;
                    r_acc_code <= 4'h0;
                end else begin
                    r_acc_n    <= w_tot_n;
                    r_acc_code <= w_frame_code;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_code  <= 4'h0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_code  <= w_code_nx;
        end
    end

    // Debounce FSM; only frame ends move it.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_code_nx  = r_code;
        w_accept   = 1'b0;
        w_acc_code = r_code;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_tot_n == 2'd1) begin
                        w_code_nx = w_frame_code;
                        if (DEBOUNCE == 1) begin
                            w_accept   = 1'b1;
                            w_acc_code = w_frame_code;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx   = CNT_W'(1);
                            w_state_nx = S_PRESS_CHK;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (w_tot_n == 2'd1 && w_frame_code == r_code) begin
                        if (r_cnt + CNT_W'(1) == DEB_N) begin
                            w_accept   = 1'b1;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_tot_n == 2'd0) begin
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = (DEBOUNCE == 1) ? S_IDLE : S_RELEASE_CHK;
                    end
                end
                default: begin
                    if (w_tot_n != 2'd0) begin
                        w_state_nx = S_HELD;
                    end else if (r_cnt + CNT_W'(1) == DEB_N) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Entry actions; iClear overrides the buffer update of a coincident key.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_kv       <= 1'b0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
            r_key_code <= 4'h0;
            r_entry    <= 28'h0;
            r_count    <= 3'd0;
            r_id       <= 28'h0;
        end else begin
            r_kv  <= w_accept;
            r_rdy <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) r_key_code <= w_acc_code;
            if (iClear) begin
                r_entry <= 28'h0;
                r_count <= 3'd0;
            end else if (w_accept) begin
                if (w_acc_code <= 4'd9) begin
                    if (r_count != 3'd7) begin
                        r_entry <= {r_entry[23:0], w_acc_code};
                        r_count <= r_count + 3'd1;
                    end
                end else if (w_acc_code == 4'hE) begin
                    if (r_count != 3'd0) begin
                        r_entry <= {4'h0, r_entry[27:4]};
                        r_count <= r_count - 3'd1;
                    end
                end else if (w_acc_code == 4'hF) begin
                    if (r_count == 3'd7) begin
                        r_id    <= r_entry;
                        r_rdy   <= 1'b1;
                        r_entry <= 28'h0;
                        r_count <= 3'd0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign oKeyValid   = r_kv;
    assign oKeyCode    = r_key_code;
    assign oEntry      = r_entry;
    assign oDigitCount = r_count;
    assign oID         = r_id;
    assign oIDReady    = r_rdy;
    assign oEntryErr   = r_err;

endmodule

// File: tb/tb_keypad_id_entry.sv
// Bench for keypad_id_entry: a switch-matrix model drives iROW from oCOL; directed vectors
// check scanning, debounce timing, entry editing, commit/error pulses, clear and reset.
module tb_keypad_id_entry;

    logic        clk = 1'b0;
    logic        iRST, iClear;
    logic [3:0]  iROW, oCOL, oKeyCode;
    logic        oKeyValid, oIDReady, oEntryErr;
    logic [27:0] oEntry, oID;
    logic [2:0]  oDigitCount;
    logic [15:0] keys;

    int n_vec = 0;
    int n_bad = 0;
    int tot_kv = 0, tot_rdy = 0, tot_err = 0;

    keypad_id_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .iCLK(clk), .iRST(iRST), .iROW(iROW), .oCOL(oCOL), .iClear(iClear),
        .oKeyValid(oKeyValid), .oKeyCode(oKeyCode), .oEntry(oEntry),
        .oDigitCount(oDigitCount), .oID(oID), .oIDReady(oIDReady), .oEntryErr(oEntryErr)
    );

    always #5 clk = ~clk;

    // Closed switch (r,c) pulls row r low while column c is driven low.
    always_comb begin
        iROW = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !oCOL[c]) iROW[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (oKeyValid) tot_kv++;
        if (oIDReady)  tot_rdy++;
        if (oEntryErr) tot_err++;
    end

    typedef struct {
        logic [3:0]  key;
        logic [27:0] entry;
        logic [2:0]  cnt;
        logic [27:0] id;
        int          rdy;
        int          err;
    } vec_t;

    vec_t vecs[13];

    function automatic int key_idx(input logic [3:0] code);
        case (code)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        keys = 16'(1) << key_idx(code);
        repeat (64) @(negedge clk);
        keys = 16'h0;
        repeat (64) @(negedge clk);
    endtask

    task automatic wait_frame_start();
        logic [3:0] prev;
        bit         found = 0;
        prev = oCOL;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && oCOL == 4'b1110) found = 1;
            prev = oCOL;
        end
        chk("frame_start_seen", 32'(found), 32'd1);
    endtask

    // From reset release (cycle 0), record the first cycle oKeyValid is high.
    task automatic first_pulse(input string name);
        int first = -1;
        int npulse = 0;
        for (int k = 0; k <= 48; k++) begin
            if (k > 0) @(negedge clk);
            if (oKeyValid) begin
                npulse++;
                if (first < 0) first = k;
            end
        end
        chk({name, "_first_cycle"}, 32'(first), 32'd32);
        chk({name, "_pulse_count"}, 32'(npulse), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int kv0, rdy0, err0, col_err, quiet_err;
        logic [3:0] exp_col;

        vecs[0]  = '{4'h1, 28'h0000001, 3'd1, 28'h0, 0, 0};
        vecs[1]  = '{4'h2, 28'h0000012, 3'd2, 28'h0, 0, 0};
        vecs[2]  = '{4'h3, 28'h0000123, 3'd3, 28'h0, 0, 0};
        vecs[3]  = '{4'h4, 28'h0001234, 3'd4, 28'h0, 0, 0};
        vecs[4]  = '{4'h5, 28'h0012345, 3'd5, 28'h0, 0, 0};
        vecs[5]  = '{4'h6, 28'h0123456, 3'd6, 28'h0, 0, 0};
        vecs[6]  = '{4'h7, 28'h1234567, 3'd7, 28'h0, 0, 0};
        vecs[7]  = '{4'h8, 28'h1234567, 3'd7, 28'h0, 0, 0};
        vecs[8]  = '{4'hE, 28'h0123456, 3'd6, 28'h0, 0, 0};
        vecs[9]  = '{4'h9, 28'h1234569, 3'd7, 28'h0, 0, 0};
        vecs[10] = '{4'hF, 28'h0000000, 3'd0, 28'h1234569, 1, 0};
        vecs[11] = '{4'h4, 28'h0000004, 3'd1, 28'h1234569, 0, 0};
        vecs[12] = '{4'hF, 28'h0000004, 3'd1, 28'h1234569, 0, 1};

        keys = 16'h0; iClear = 1'b0; iRST = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_col", 32'(oCOL), 32'hE);
        chk("rst_keyvalid", 32'(oKeyValid), 32'd0);
        chk("rst_keycode", 32'(oKeyCode), 32'd0);
        chk("rst_entry", 32'(oEntry), 32'd0);
        chk("rst_count", 32'(oDigitCount), 32'd0);
        chk("rst_id", 32'(oID), 32'd0);
        chk("rst_idready", 32'(oIDReady), 32'd0);
        chk("rst_entryerr", 32'(oEntryErr), 32'd0);

        // Idle scan rotation
        iRST = 1'b0;
        col_err = 0; quiet_err = 0;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            if (oCOL !== exp_col) col_err++;
            if (oKeyValid || oIDReady || oEntryErr || oEntry != 0 || oDigitCount != 0 ||
                oID != 0 || oKeyCode != 0) quiet_err++;
        end
        chk("idle_col_rotation_errs", 32'(col_err), 32'd0);
        chk("idle_quiet_errs", 32'(quiet_err), 32'd0);

        // Clean '5' from reset: pulse exactly in cycle 32
        iRST = 1'b1;
        keys = 16'(1) << key_idx(4'h5);
        @(negedge clk);
        iRST = 1'b0;
        first_pulse("press5");
        chk("press5_code", 32'(oKeyCode), 32'h5);
        chk("press5_entry", 32'(oEntry), 32'h5);
        chk("press5_count", 32'(oDigitCount), 32'd1);
        kv0 = tot_kv;
        repeat (160) @(negedge clk);
        chk("hold5_no_repeat", 32'(tot_kv - kv0), 32'd0);
        keys = 16'h0;
        repeat (64) @(negedge clk);

        // Bouncing '8': alternating frames never reach two in a row
        wait_frame_start();
        kv0 = tot_kv;
        for (int b = 0; b < 4; b++) begin
            keys = (b % 2 == 0) ? (16'(1) << key_idx(4'h8)) : 16'h0;
            repeat (16) @(negedge clk);
        end
        chk("bounce8_no_pulse", 32'(tot_kv - kv0), 32'd0);
        keys = 16'(1) << key_idx(4'h8);
        repeat (48) @(negedge clk);
        chk("hold8_pulses", 32'(tot_kv - kv0), 32'd1);
        chk("hold8_code", 32'(oKeyCode), 32'h8);
        chk("hold8_entry", 32'(oEntry), 32'h58);
        keys = 16'h0;
        repeat (64) @(negedge clk);

        // '8' and '9' together
        kv0 = tot_kv;
        keys = (16'(1) << key_idx(4'h8)) | (16'(1) << key_idx(4'h9));
        repeat (80) @(negedge clk);
        chk("multi_no_pulse", 32'(tot_kv - kv0), 32'd0);
        chk("multi_entry", 32'(oEntry), 32'h58);
        keys = 16'h0;
        repeat (64) @(negedge clk);

        iClear = 1'b1;
        @(negedge clk);
        iClear = 1'b0;
        chk("clear_entry", 32'(oEntry), 32'd0);
        chk("clear_count", 32'(oDigitCount), 32'd0);

        // Entry / backspace / enter table
        for (int v = 0; v < 13; v++) begin
            kv0 = tot_kv; rdy0 = tot_rdy; err0 = tot_err;
            press(vecs[v].key);
            chk($sformatf("v%0d_kv", v), 32'(tot_kv - kv0), 32'd1);
            chk($sformatf("v%0d_code", v), 32'(oKeyCode), 32'(vecs[v].key));
            chk($sformatf("v%0d_entry", v), 32'(oEntry), 32'(vecs[v].entry));
            chk($sformatf("v%0d_count", v), 32'(oDigitCount), 32'(vecs[v].cnt));
            chk($sformatf("v%0d_id", v), 32'(oID), 32'(vecs[v].id));
            chk($sformatf("v%0d_rdy", v), 32'(tot_rdy - rdy0), 32'(vecs[v].rdy));
            chk($sformatf("v%0d_err", v), 32'(tot_err - err0), 32'(vecs[v].err));
        end

        // iClear in the acceptance cycle of a 4th digit
        iClear = 1'b1;
        @(negedge clk);
        iClear = 1'b0;
        press(4'h1); press(4'h2); press(4'h3);
        chk("pre_clear_entry", 32'(oEntry), 32'h123);
        wait_frame_start();
        keys = 16'(1) << key_idx(4'h4);
        repeat (31) @(negedge clk);
        iClear = 1'b1;
        @(negedge clk);
        iClear = 1'b0;
        chk("clrkey_kv", 32'(oKeyValid), 32'd1);
        chk("clrkey_code", 32'(oKeyCode), 32'h4);
        chk("clrkey_entry", 32'(oEntry), 32'd0);
        chk("clrkey_count", 32'(oDigitCount), 32'd0);
        chk("clrkey_id", 32'(oID), 32'h1234569);
        keys = 16'h0;
        repeat (64) @(negedge clk);

        // Reset while in PRESS_CHK, key kept held
        wait_frame_start();
        keys = 16'(1) << key_idx(4'h6);
        repeat (20) @(negedge clk);
        iRST = 1'b1;
        #1;
        chk("midrst_col", 32'(oCOL), 32'hE);
        chk("midrst_keycode", 32'(oKeyCode), 32'd0);
        chk("midrst_id", 32'(oID), 32'd0);
        chk("midrst_count", 32'(oDigitCount), 32'd0);
        @(negedge clk);
        iRST = 1'b0;
        first_pulse("post_rst6");
        chk("post_rst6_entry", 32'(oEntry), 32'h6);
        keys = 16'h0;
        repeat (16) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
